// File: rtl/simplebus_mem_slave.sv
// simplebus_mem_slave: SimpleBus slave memory with fixed-latency in-order responses.
// Ports: clk/rst (async, active-high); req_* request channel (req_ready combinational);
// resp_* response channel with back-pressure; flush drops pending responses;
// empty flags no pending responses; rd_cnt/wr_cnt count accepted reads/writes (wrapping).
module simplebus_mem_slave #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int USER_W  = 16,
  parameter int DEPTH   = 1024,
  parameter int QDEPTH  = 4,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic                req_ready,
  input  logic                req_valid,
  input  logic [ADDR_W-1:0]   req_bits_addr,
  input  logic [2:0]          req_bits_size,
  input  logic [3:0]          req_bits_cmd,
  input  logic [DATA_W/8-1:0] req_bits_wmask,
  input  logic [DATA_W-1:0]   req_bits_wdata,
  input  logic [USER_W-1:0]   req_bits_user,
  input  logic                resp_ready,
  output logic                resp_valid,
  output logic [3:0]          resp_bits_cmd,
  output logic [DATA_W-1:0]   resp_bits_rdata,
  output logic [USER_W-1:0]   resp_bits_user,
  input  logic                flush,
  output logic                empty,
  output logic [31:0]         rd_cnt,
  output logic [31:0]         wr_cnt
);
  localparam int BW  = DATA_W / 8;
  localparam int OFF = $clog2(BW);
  localparam int IW  = $clog2(DEPTH);
  localparam int PW  = QDEPTH > 1 ? $clog2(QDEPTH) : 1;
  localparam int CW  = $clog2(QDEPTH + 1);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [3:0]        q_cmd [QDEPTH];
  logic [DATA_W-1:0] q_rdata [QDEPTH];
  logic [USER_W-1:0] q_user [QDEPTH];
  logic [31:0]       q_due [QDEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       cyc_q, rd_cnt_q, wr_cnt_q;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] wr_word;
  logic              acc, pop, is_rd, is_wr, due_ok;
  logic              unused_ok;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(QDEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign unused_ok = ^{req_bits_size, req_bits_addr[ADDR_W-1:OFF+IW], req_bits_addr[OFF-1:0]};
  assign idx       = req_bits_addr[OFF+IW-1:OFF];
  assign is_rd     = req_bits_cmd == 4'b0000;
  assign is_wr     = req_bits_cmd == 4'b0001;
  assign req_ready = !flush && (cnt_q < CW'(QDEPTH));
  assign acc       = req_valid && req_ready;
  // Signed difference keeps the due check correct across cycle-counter wrap.
  assign due_ok    = $signed(cyc_q - q_due[head_q]) >= 0;
  assign resp_valid = (cnt_q != '0) && due_ok;
  assign pop       = resp_valid && resp_ready;
  assign empty     = cnt_q == '0;
  assign resp_bits_cmd   = resp_valid ? q_cmd[head_q] : '0;
  assign resp_bits_rdata = resp_valid ? q_rdata[head_q] : '0;
  assign resp_bits_user  = resp_valid ? q_user[head_q] : '0;
  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;
  always_comb begin
    wr_word = mem_q[idx];
    for (int b = 0; b < BW; b++)
      wr_word[b*8 +: 8] = req_bits_wmask[b] ? req_bits_wdata[b*8 +: 8] : wr_word[b*8 +: 8];
  end
  always_comb begin
    head_d = flush ? '0 : pop ? nxt(head_q) : head_q;
    tail_d = flush ? '0 : acc ? nxt(tail_q) : tail_q;
    cnt_d  = flush ? '0 : cnt_q + CW'(acc) - CW'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
      cyc_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
      cyc_q    <= cyc_q + 32'd1;
      rd_cnt_q <= rd_cnt_q + 32'(acc && is_rd);
      wr_cnt_q <= wr_cnt_q + 32'(acc && is_wr);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (acc && is_wr) begin
      mem_q[idx] <= wr_word;
    end
  end
  // Entries are only observed while counted, so they need no reset.
  always_ff @(posedge clk) begin
    if (acc) begin
      q_cmd[tail_q]   <= is_wr ? 4'b0101 : 4'b0110;
      q_rdata[tail_q] <= is_rd ? mem_q[idx] : '0;
      q_user[tail_q]  <= req_bits_user;
      q_due[tail_q]   <= cyc_q + 32'(LATENCY);
    end
  end
endmodule

// File: tb/tb_simplebus_mem_slave.sv
// tb_simplebus_mem_slave: directed self-checking bench for simplebus_mem_slave.
module tb_simplebus_mem_slave;
  logic        clk = 0, rst = 1;
  logic        req_ready, req_valid = 0;
  logic [31:0] req_bits_addr = 0;
  logic [2:0]  req_bits_size = 3'd3;
  logic [3:0]  req_bits_cmd = 0;
  logic [7:0]  req_bits_wmask = 0;
  logic [63:0] req_bits_wdata = 0;
  logic [15:0] req_bits_user = 0;
  logic        resp_ready = 1, resp_valid;
  logic [3:0]  resp_bits_cmd;
  logic [63:0] resp_bits_rdata;
  logic [15:0] resp_bits_user;
  logic        flush = 0, empty;
  logic [31:0] rd_cnt, wr_cnt;
  int vectors = 0, errors = 0;
  simplebus_mem_slave dut (
    .clk(clk), .rst(rst), .req_ready(req_ready), .req_valid(req_valid),
    .req_bits_addr(req_bits_addr), .req_bits_size(req_bits_size), .req_bits_cmd(req_bits_cmd),
    .req_bits_wmask(req_bits_wmask), .req_bits_wdata(req_bits_wdata), .req_bits_user(req_bits_user),
    .resp_ready(resp_ready), .resp_valid(resp_valid), .resp_bits_cmd(resp_bits_cmd),
    .resp_bits_rdata(resp_bits_rdata), .resp_bits_user(resp_bits_user),
    .flush(flush), .empty(empty), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [3:0] cmd, input logic [31:0] addr, input logic [63:0] wdata,
                      input logic [7:0] wmask, input logic [15:0] user, output logic ok);
    req_bits_cmd = cmd; req_bits_addr = addr; req_bits_wdata = wdata;
    req_bits_wmask = wmask; req_bits_user = user; req_valid = 1;
    @(negedge clk);
    ok = req_ready;
    tick();
    req_valid = 0;
  endtask
  task automatic wait_resp(output logic ok);
    for (int i = 0; i < 20 && !resp_valid; i++) tick();
    ok = resp_valid;
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && !empty; i++) tick();
  endtask
  task automatic test_reset();
    rst = 1;
    tick(); tick();
    vectors++; if ({req_ready, resp_valid, empty} !== 3'b101) begin errors++; $display("FAIL reset_flags: got %b want 101", {req_ready, resp_valid, empty}); end
    vectors++; if ({resp_bits_cmd, resp_bits_rdata, resp_bits_user} !== '0) begin errors++; $display("FAIL reset_bits: got %h/%h/%h want 0", resp_bits_cmd, resp_bits_rdata, resp_bits_user); end
    vectors++; if ({rd_cnt, wr_cnt} !== 64'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", rd_cnt, wr_cnt); end
    rst = 0;
  endtask
  task automatic test_write_read();
    logic ok;
    resp_ready = 1;
    send(4'b0001, 32'h80, 64'h1122334455667788, 8'hFF, 16'h11, ok);
    vectors++; if (ok !== 1'b1) begin errors++; $display("FAIL wr_accept: got %b want 1", ok); end
    vectors++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL wr_early: got %b want 0", resp_valid); end
    tick();
    vectors++; if ({resp_valid, resp_bits_cmd, resp_bits_rdata, resp_bits_user} !== {1'b1, 4'b0101, 64'h0, 16'h11})
      begin errors++; $display("FAIL wr_resp: got %b %b %h %h want 1 0101 0 0011", resp_valid, resp_bits_cmd, resp_bits_rdata, resp_bits_user); end
    vectors++; if (wr_cnt !== 32'd1) begin errors++; $display("FAIL wr_cnt1: got %0d want 1", wr_cnt); end
    send(4'b0000, 32'h80, 64'h0, 8'h0, 16'h22, ok);
    vectors++; if ({ok, resp_valid, empty} !== 3'b100) begin errors++; $display("FAIL rd_early: got %b want 100", {ok, resp_valid, empty}); end
    tick();
    vectors++; if ({resp_valid, resp_bits_cmd, resp_bits_rdata, resp_bits_user} !== {1'b1, 4'b0110, 64'h1122334455667788, 16'h22})
      begin errors++; $display("FAIL rd_resp: got %b %b %h %h want 1 0110 1122334455667788 0022", resp_valid, resp_bits_cmd, resp_bits_rdata, resp_bits_user); end
    vectors++; if (rd_cnt !== 32'd1) begin errors++; $display("FAIL rd_cnt1: got %0d want 1", rd_cnt); end
    tick();
    vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL wr_rd_empty: got %b want 1", empty); end
  endtask
  task automatic test_byte_mask();
    logic ok;
    send(4'b0001, 32'h8, '1, 8'h0F, 16'h31, ok);
    wait_resp(ok);
    send(4'b0000, 32'h8, 64'h0, 8'h0, 16'h32, ok);
    wait_resp(ok);
    vectors++; if ({ok, resp_bits_rdata, resp_bits_user} !== {1'b1, 64'h00000000FFFFFFFF, 16'h32})
      begin errors++; $display("FAIL byte_mask: got %b %h %h want 1 00000000ffffffff 0032", ok, resp_bits_rdata, resp_bits_user); end
    drain();
  endtask
  task automatic test_alias();
    logic ok;
    send(4'b0001, 32'h2008, 64'hA5A5_5A5A_0123_4567, 8'hFF, 16'h33, ok);
    wait_resp(ok);
    send(4'b0000, 32'h8, 64'h0, 8'h0, 16'h34, ok);
    wait_resp(ok);
    vectors++; if ({ok, resp_bits_rdata} !== {1'b1, 64'hA5A5_5A5A_0123_4567}) begin errors++; $display("FAIL alias: got %b %h want 1 a5a55a5a01234567", ok, resp_bits_rdata); end
    drain();
    vectors++; if ({rd_cnt, wr_cnt} !== {32'd3, 32'd3}) begin errors++; $display("FAIL alias_cnt: got %0d/%0d want 3/3", rd_cnt, wr_cnt); end
  endtask
  task automatic test_back_to_back();
    logic ok;
    send(4'b0000, 32'h80, 64'h0, 8'h0, 16'h50, ok);
    vectors++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_first: got %b want 0", resp_valid); end
    send(4'b0000, 32'h80, 64'h0, 8'h0, 16'h51, ok);
    vectors++; if ({resp_valid, resp_bits_user} !== {1'b1, 16'h50}) begin errors++; $display("FAIL b2b_r0: got %b %h want 1 0050", resp_valid, resp_bits_user); end
    send(4'b0010, 32'h80, 64'h0, 8'h0, 16'h52, ok);
    vectors++; if ({resp_valid, resp_bits_user, resp_bits_rdata} !== {1'b1, 16'h51, 64'h1122334455667788})
      begin errors++; $display("FAIL b2b_r1: got %b %h %h want 1 0051 1122334455667788", resp_valid, resp_bits_user, resp_bits_rdata); end
    tick();
    vectors++; if ({resp_valid, resp_bits_user, resp_bits_cmd, resp_bits_rdata} !== {1'b1, 16'h52, 4'b0110, 64'h0})
      begin errors++; $display("FAIL b2b_other: got %b %h %b %h want 1 0052 0110 0", resp_valid, resp_bits_user, resp_bits_cmd, resp_bits_rdata); end
    tick();
    vectors++; if ({empty, rd_cnt, wr_cnt} !== {1'b1, 32'd5, 32'd3}) begin errors++; $display("FAIL b2b_end: got %b %0d %0d want 1 5 3", empty, rd_cnt, wr_cnt); end
  endtask
  task automatic test_backpressure();
    logic ok;
    logic [3:0] accs;
    resp_ready = 0;
    for (int k = 0; k < 4; k++) begin
      send(4'b0000, 32'h80, 64'h0, 8'h0, 16'h40 + 16'(k), ok);
      accs[k] = ok;
    end
    vectors++; if (accs !== 4'hF) begin errors++; $display("FAIL bp_accepts: got %b want 1111", accs); end
    req_bits_user = 16'h44; req_valid = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vectors++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got %b want 0", req_ready); end
      tick();
    end
    req_valid = 0;
    vectors++; if ({resp_valid, resp_bits_user, rd_cnt} !== {1'b1, 16'h40, 32'd9}) begin errors++; $display("FAIL bp_hold: got %b %h %0d want 1 0040 9", resp_valid, resp_bits_user, rd_cnt); end
    resp_ready = 1;
    for (int k = 0; k < 4; k++) begin
      vectors++; if ({resp_valid, resp_bits_user} !== {1'b1, 16'h40 + 16'(k)}) begin errors++; $display("FAIL bp_drain%0d: got %b %h want 1 %h", k, resp_valid, resp_bits_user, 16'h40 + 16'(k)); end
      tick();
    end
    vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL bp_empty: got %b want 1", empty); end
    send(4'b0000, 32'h80, 64'h0, 8'h0, 16'h44, ok);
    wait_resp(ok);
    vectors++; if ({ok, resp_bits_user, rd_cnt} !== {1'b1, 16'h44, 32'd10}) begin errors++; $display("FAIL bp_fifth: got %b %h %0d want 1 0044 10", ok, resp_bits_user, rd_cnt); end
    drain();
  endtask
  task automatic test_flush();
    logic ok;
    resp_ready = 0;
    for (int k = 0; k < 3; k++) send(4'b0000, 32'h80, 64'h0, 8'h0, 16'h60 + 16'(k), ok);
    flush = 1; req_valid = 1; req_bits_user = 16'h63;
    @(negedge clk);
    vectors++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", req_ready); end
    tick();
    flush = 0; req_valid = 0;
    vectors++; if ({resp_valid, empty, rd_cnt} !== {1'b0, 1'b1, 32'd13}) begin errors++; $display("FAIL flush_after: got %b %b %0d want 0 1 13", resp_valid, empty, rd_cnt); end
    resp_ready = 1;
    ok = 0;
    for (int k = 0; k < 6; k++) begin tick(); ok |= resp_valid; end
    vectors++; if (ok !== 1'b0) begin errors++; $display("FAIL flush_stale: got %b want 0", ok); end
  endtask
  task automatic test_async_reset();
    logic ok;
    send(4'b0001, 32'h100, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 16'h70, ok);
    drain();
    resp_ready = 0;
    send(4'b0000, 32'h100, 64'h0, 8'h0, 16'h71, ok);
    send(4'b0000, 32'h100, 64'h0, 8'h0, 16'h72, ok);
    #2 rst = 1;
    #1;
    vectors++; if ({req_ready, resp_valid, empty} !== 3'b101) begin errors++; $display("FAIL arst_flags: got %b want 101", {req_ready, resp_valid, empty}); end
    vectors++; if ({rd_cnt, wr_cnt, resp_bits_user} !== '0) begin errors++; $display("FAIL arst_cnt: got %0d %0d %h want 0 0 0", rd_cnt, wr_cnt, resp_bits_user); end
    tick();
    rst = 0; resp_ready = 1;
    send(4'b0000, 32'h100, 64'h0, 8'h0, 16'h73, ok);
    wait_resp(ok);
    vectors++; if ({ok, resp_bits_rdata, resp_bits_user, rd_cnt} !== {1'b1, 64'h0, 16'h73, 32'd1})
      begin errors++; $display("FAIL arst_mem: got %b %h %h %0d want 1 0 0073 1", ok, resp_bits_rdata, resp_bits_user, rd_cnt); end
    drain();
  endtask
  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_alias();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
